// File: rtl/sifh_pkg.sv
// Shared constants and types for the SiFH histogram builder.
// All derived widths are computed here so every block agrees on them.
package sifh_pkg;

    localparam int NP                = 10;
    localparam int BIN_BITS          = 4;
    localparam int PIXEL_NUM         = 3;
    localparam int PIXEL_NUM_PER_RAM = 3;
    localparam int ACQ_NUM           = 2;
    localparam int DATA_NUM          = 2;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    localparam int CW    = $clog2(ACQ_NUM * DATA_NUM + 1);
    localparam int NBINS = 1 << BIN_BITS;
    localparam int PIX_W = clog2_min1(PIXEL_NUM);
    localparam int DAT_W = clog2_min1(DATA_NUM);
    localparam int ACQ_W = clog2_min1(ACQ_NUM);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/pixel_hist.sv
// Per-pixel bin counters with a running maximum and peak bin.
// peak_bin_o already includes the word being accumulated this cycle.
module pixel_hist
    import sifh_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                inc_i,
    input  logic                clr_i,
    input  logic [BIN_BITS-1:0] bin_i,
    output logic [BIN_BITS-1:0] peak_bin_o
);

    logic [CW-1:0]       cnt_q [NBINS];
    logic [CW-1:0]       cnt_new;
    logic [CW-1:0]       max_q, max_d;
    logic [BIN_BITS-1:0] peak_q, peak_d;

    // Strict compare keeps the bin that reached the max first.
    always_comb begin
        cnt_new = cnt_q[bin_i] + CW'(1);
        max_d   = max_q;
        peak_d  = peak_q;
        if (inc_i && (cnt_new > max_q)) begin
            max_d  = cnt_new;
            peak_d = bin_i;
        end
    end

    assign peak_bin_o = peak_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBINS; b++) cnt_q[b] <= '0;
            max_q  <= '0;
            peak_q <= '0;
        end else if (clr_i) begin
            for (int b = 0; b < NBINS; b++) cnt_q[b] <= '0;
            max_q  <= '0;
            peak_q <= '0;
        end else if (inc_i) begin
            cnt_q[bin_i] <= cnt_new;
            max_q        <= max_d;
            peak_q       <= peak_d;
        end
    end

endmodule

// File: rtl/his_builder_fsm.sv
// Streaming per-pixel histogram builder: walks pixel/data/acq indices,
// and publishes each pixel's peak bin lower edge on the frame's last word.
module his_builder_fsm
    import sifh_pkg::*;
(
    input  logic          clk,
    input  logic          res,
    input  logic          wrEn,
    input  logic [NP-1:0] data,
    output logic [NP-1:0] peakResult [PIXEL_NUM_PER_RAM]
);

    state_e             state_q, state_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic [ACQ_W-1:0]   acq_q, acq_d;
    logic               last_word;
    logic               publish;
    logic [BIN_BITS-1:0] bin;
    logic [BIN_BITS-1:0] peak_bin [PIXEL_NUM];
    logic [NP-1:0]      result_q [PIXEL_NUM_PER_RAM];

    assign bin = data[NP-1 -: BIN_BITS];

    assign last_word = (dat_q == DAT_W'(DATA_NUM - 1)) &&
                       (pix_q == PIX_W'(PIXEL_NUM - 1)) &&
                       (acq_q == ACQ_W'(ACQ_NUM - 1));

    assign publish = wrEn && last_word;

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        dat_d   = dat_q;
        acq_d   = acq_q;
        unique case (state_q)
            IDLE:    if (wrEn) state_d = ACCUM;
            ACCUM:   state_d = ACCUM;
            default: state_d = IDLE;
        endcase
        if (wrEn) begin
            if (dat_q == DAT_W'(DATA_NUM - 1)) begin
                dat_d = '0;
                if (pix_q == PIX_W'(PIXEL_NUM - 1)) begin
                    pix_d = '0;
                    if (acq_q == ACQ_W'(ACQ_NUM - 1)) acq_d = '0;
                    else                              acq_d = acq_q + ACQ_W'(1);
                end else begin
                    pix_d = pix_q + PIX_W'(1);
                end
            end else begin
                dat_d = dat_q + DAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= IDLE;
            pix_q   <= '0;
            dat_q   <= '0;
            acq_q   <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            dat_q   <= dat_d;
            acq_q   <= acq_d;
        end
    end

    for (genvar p = 0; p < PIXEL_NUM; p++) begin : g_pix
        pixel_hist u_hist (
            .clk        (clk),
            .rst        (res),
            .inc_i      (wrEn && (pix_q == PIX_W'(p))),
            .clr_i      (publish),
            .bin_i      (bin),
            .peak_bin_o (peak_bin[p])
        );
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) result_q[p] <= '0;
        end else if (publish) begin
            for (int p = 0; p < PIXEL_NUM_PER_RAM; p++)
                result_q[p] <= {peak_bin[p], {(NP - BIN_BITS){1'b0}}};
        end
    end

    assign peakResult = result_q;

endmodule

// File: tb/tb_his_builder_fsm.sv
// Self-checking bench: frame-level histogram model checked every cycle,
// plus literal expectations for the directed frames.
module tb_his_builder_fsm;
    import sifh_pkg::*;

    localparam int F = PIXEL_NUM * ACQ_NUM * DATA_NUM;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          wrEn = 1'b0;
    logic [NP-1:0] data = '0;
    logic [NP-1:0] peakResult [PIXEL_NUM_PER_RAM];

    int n_tests = 0;
    int n_fail  = 0;

    logic [NP-1:0] exp_res [PIXEL_NUM_PER_RAM];
    logic [NP-1:0] words [$];

    his_builder_fsm dut (
        .clk        (clk),
        .res        (res),
        .wrEn       (wrEn),
        .data       (data),
        .peakResult (peakResult)
    );

    always #5 clk = ~clk;

    // Rebuild the frame histogram from the accepted words in arrival order.
    function automatic void compute_frame();
        int cnt [PIXEL_NUM][NBINS];
        int mx  [PIXEL_NUM];
        int pk  [PIXEL_NUM];
        for (int p = 0; p < PIXEL_NUM; p++) begin
            mx[p] = 0;
            pk[p] = 0;
            for (int b = 0; b < NBINS; b++) cnt[p][b] = 0;
        end
        for (int i = 0; i < F; i++) begin
            int p, b;
            p = (i / DATA_NUM) % PIXEL_NUM;
            b = int'(words[i]) / (1 << (NP - BIN_BITS));
            cnt[p][b]++;
            if (cnt[p][b] > mx[p]) begin
                mx[p] = cnt[p][b];
                pk[p] = b;
            end
        end
        for (int p = 0; p < PIXEL_NUM; p++)
            exp_res[p] = NP'(pk[p] * (1 << (NP - BIN_BITS)));
    endfunction

    always @(posedge clk or posedge res) begin
        if (res) begin
            words.delete();
            for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) exp_res[p] = '0;
        end else if (wrEn) begin
            words.push_back(data);
            if (words.size() == F) begin
                compute_frame();
                words.delete();
            end
        end
    end

    always @(negedge clk) begin
        for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
            n_tests++;
            if (peakResult[p] !== exp_res[p]) begin
                n_fail++;
                $display("FAIL model peakResult[%0d] t=%0t got %0d expected %0d",
                         p, $time, peakResult[p], exp_res[p]);
            end
        end
    end

    task automatic check(input string name, input int p, input int expv);
        n_tests++;
        if (peakResult[p] !== NP'(expv)) begin
            n_fail++;
            $display("FAIL %s peakResult[%0d] got %0d expected %0d",
                     name, p, peakResult[p], expv);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        wrEn = 1'b0;
        data = NP'($urandom);
    endtask

    task automatic put(input logic [NP-1:0] d);
        @(posedge clk); #1;
        wrEn = 1'b1;
        data = d;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        res = 1'b1;
        wrEn = 1'b0;
        @(posedge clk); #1;
        res = 1'b0;
    endtask

    int f1 [F] = '{108, 511, 1022, 1022, 200, 90, 511, 1023, 90, 90, 90, 1023};
    int f2 [F] = '{300, 500, 50, 1000, 48, 90, 600, 500, 1000, 1023, 120, 90};

    initial begin
        // Reset with wrEn toggling: nothing may be accumulated.
        res = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            wrEn = i[0];
            data = 10'd1023;
        end
        for (int p = 0; p < PIXEL_NUM; p++) check("reset", p, 0);
        @(posedge clk); #1;
        wrEn = 1'b0;
        res  = 1'b0;

        for (int i = 0; i < F; i++) put(NP'(f1[i]));
        idle_cycle();
        check("frame1", 0, 448);
        check("frame1", 1, 960);
        check("frame1", 2, 64);

        // Back-to-back frame; frame-1 values must hold until its publish.
        for (int i = 0; i < F; i++) begin
            put(NP'(f2[i]));
            if (i == F - 1) begin
                check("hold", 0, 448);
                check("hold", 1, 960);
            end
        end
        idle_cycle();
        check("frame2", 0, 448);
        check("frame2", 1, 960);
        check("frame2", 2, 64);

        // Random stalls, plus a guaranteed stall right before the last word.
        for (int i = 0; i < F; i++) begin
            if ($urandom_range(0, 1) == 1) idle_cycle();
            if (i == F - 1) begin
                idle_cycle();
                idle_cycle();
            end
            put(NP'(f1[i]));
        end
        idle_cycle();
        check("stall", 0, 448);
        check("stall", 1, 960);
        check("stall", 2, 64);

        // Mid-frame reset discards partial words.
        for (int i = 0; i < 5; i++) put(NP'(f2[i]));
        pulse_reset();
        for (int p = 0; p < PIXEL_NUM; p++) check("midrst", p, 0);
        for (int i = 0; i < F; i++) put(NP'(f1[i]));
        idle_cycle();
        check("midrst_frame", 0, 448);
        check("midrst_frame", 1, 960);
        check("midrst_frame", 2, 64);

        for (int i = 0; i < F; i++) put(NP'(1023));
        idle_cycle();
        for (int p = 0; p < PIXEL_NUM; p++) check("all_max", p, 960);

        for (int i = 0; i < F; i++) put(NP'(0));
        idle_cycle();
        for (int p = 0; p < PIXEL_NUM; p++) check("all_zero", p, 0);

        idle_cycle();
        idle_cycle();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
